// File: rtl/nabp_processing_data_path_checker_if.sv
// Host/PE-facing bundle of the data path checker: config, RAM-stub ports, PE taps and result status.
interface nabp_processing_data_path_checker_if #(
  parameter int NUM_PORTS      = 2,
  parameter int S_WIDTH        = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_PARTITIONS = 4,
  parameter int FRAC_BITS      = 8,
  parameter int ERR_CNT_WIDTH  = 16
);
  localparam int ACC_W = S_WIDTH + FRAC_BITS + 1;
  localparam int TAP_W = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;

  logic                                  cfg_start;
  logic signed [ACC_W-1:0]               cfg_s0;
  logic signed [ACC_W-1:0]               cfg_line_step;
  logic signed [ACC_W-1:0]               cfg_scan_step;
  logic                                  cfg_reverse;
  logic [NUM_PORTS*S_WIDTH-1:0]          pv_s_val;
  logic [NUM_PORTS*DATA_WIDTH-1:0]       pv_val;
  logic                                  pe_en;
  logic [NUM_PARTITIONS*DATA_WIDTH-1:0]  pe_taps;
  logic                                  busy;
  logic                                  done;
  logic                                  pass;
  logic [ERR_CNT_WIDTH-1:0]              err_count;
  logic                                  first_err_valid;
  logic [S_WIDTH-1:0]                    first_err_scan;
  logic [TAP_W-1:0]                      first_err_tap;
  logic [DATA_WIDTH-1:0]                 first_err_actual;

  modport master (
    output cfg_start, cfg_s0, cfg_line_step, cfg_scan_step, cfg_reverse,
    output pv_s_val, pe_en, pe_taps,
    input  pv_val, busy, done, pass, err_count,
    input  first_err_valid, first_err_scan, first_err_tap, first_err_actual
  );

  modport slave (
    input  cfg_start, cfg_s0, cfg_line_step, cfg_scan_step, cfg_reverse,
    input  pv_s_val, pe_en, pe_taps,
    output pv_val, busy, done, pass, err_count,
    output first_err_valid, first_err_scan, first_err_tap, first_err_actual
  );
endinterface

// File: rtl/nabp_processing_data_path_checker.sv
// Filtered-RAM stand-in plus PE tap scorer: compares every tap against an incrementally
// accumulated fixed-point projection position, within a tolerance, over one scan run.
//
// state | meaning
// IDLE  | no run; waiting for cfg_start
// PRIME | seeding per-partition accumulators, one per cycle
// ARMED | accumulators ready, waiting for the first pe_en (scan step 0)
// SCAN  | comparing taps on every pe_en cycle
// DONE  | one-cycle end of run; done pulse, pass valid
module nabp_processing_data_path_checker #(
  parameter int NUM_PORTS      = 2,
  parameter int S_WIDTH        = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_PARTITIONS = 4,
  parameter int RAM_LATENCY    = 1,
  parameter int FRAC_BITS      = 8,
  parameter int TOLERANCE      = 3,
  parameter int SCAN_LENGTH    = 256,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input logic clk,
  input logic reset_n,
  nabp_processing_data_path_checker_if.slave bus
);
  localparam int ACC_W     = S_WIDTH + FRAC_BITS + 1;
  localparam int TAP_W     = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;
  localparam int CNT_SUM_W = ERR_CNT_WIDTH + TAP_W + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_ARMED = 3'd2;
  localparam logic [2:0] ST_SCAN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic signed [ACC_W-1:0]    RND_HALF = ACC_W'(1 << (FRAC_BITS - 1));
  localparam logic signed [DATA_WIDTH:0] TOL_POS  = (DATA_WIDTH+1)'(TOLERANCE);
  localparam logic signed [DATA_WIDTH:0] TOL_NEG  = -(DATA_WIDTH+1)'(TOLERANCE);
  localparam logic [CNT_SUM_W-1:0]       ERR_MAX  = CNT_SUM_W'({ERR_CNT_WIDTH{1'b1}});
  localparam logic [S_WIDTH-1:0]         K_LAST   = S_WIDTH'(SCAN_LENGTH - 1);

  // RAM stub: zero-extended address returned as data after RAM_LATENCY clocks
  logic [NUM_PORTS*DATA_WIDTH-1:0] ram_in;

  always_comb begin
    ram_in = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      ram_in[p*DATA_WIDTH +: S_WIDTH] = bus.pv_s_val[p*S_WIDTH +: S_WIDTH];
  end

  generate
    if (RAM_LATENCY == 0) begin : g_comb
      assign bus.pv_val = ram_in;
    end else begin : g_pipe
      logic [NUM_PORTS*DATA_WIDTH-1:0] pipe [RAM_LATENCY];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < RAM_LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= ram_in;
          for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign bus.pv_val = pipe[RAM_LATENCY-1];
    end
  endgenerate

  logic [2:0]               state;
  logic [TAP_W-1:0]         prime_cnt;
  logic signed [ACC_W-1:0]  prime_sum;
  logic signed [ACC_W-1:0]  acc [NUM_PARTITIONS];
  logic signed [ACC_W-1:0]  line_step;
  logic signed [ACC_W-1:0]  scan_step;
  logic                     reverse;
  logic [S_WIDTH-1:0]       scan_k;
  logic [ERR_CNT_WIDTH-1:0] err_count;
  logic                     pass;
  logic                     proto_err;
  logic                     first_err_valid;
  logic [S_WIDTH-1:0]       first_err_scan;
  logic [TAP_W-1:0]         first_err_tap;
  logic [DATA_WIDTH-1:0]    first_err_actual;

  logic [DATA_WIDTH-1:0]        tap      [NUM_PARTITIONS];
  logic [DATA_WIDTH-1:0]        exp_val  [NUM_PARTITIONS];
  logic signed [DATA_WIDTH:0]   diff     [NUM_PARTITIONS];
  logic [NUM_PARTITIONS-1:0]    mism;
  logic [TAP_W:0]               mism_cnt;
  logic [TAP_W-1:0]             first_idx;
  logic [CNT_SUM_W-1:0]         err_sum;
  logic                         compare;

  assign compare = bus.pe_en && ((state == ST_ARMED) || (state == ST_SCAN));

  always_comb begin
    mism_cnt  = '0;
    first_idx = '0;
    for (int i = 0; i < NUM_PARTITIONS; i++) begin
      tap[i]     = bus.pe_taps[i*DATA_WIDTH +: DATA_WIDTH];
      exp_val[i] = DATA_WIDTH'((acc[i] + RND_HALF) >>> FRAC_BITS);
      diff[i]    = $signed({exp_val[i][DATA_WIDTH-1], exp_val[i]})
                 - $signed({tap[i][DATA_WIDTH-1], tap[i]});
      mism[i]    = compare && ((diff[i] > TOL_POS) || (diff[i] < TOL_NEG));
      mism_cnt   = mism_cnt + (TAP_W+1)'(mism[i]);
    end
    // Walk downwards so the lowest mismatching partition wins
    for (int i = NUM_PARTITIONS - 1; i >= 0; i--)
      if (mism[i]) first_idx = TAP_W'(i);
    err_sum = CNT_SUM_W'(err_count) + CNT_SUM_W'(mism_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      prime_cnt        <= '0;
      prime_sum        <= '0;
      for (int i = 0; i < NUM_PARTITIONS; i++) acc[i] <= '0;
      line_step        <= '0;
      scan_step        <= '0;
      reverse          <= 1'b0;
      scan_k           <= '0;
      err_count        <= '0;
      pass             <= 1'b0;
      proto_err        <= 1'b0;
      first_err_valid  <= 1'b0;
      first_err_scan   <= '0;
      first_err_tap    <= '0;
      first_err_actual <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.cfg_start) begin
            prime_sum        <= bus.cfg_s0;
            line_step        <= bus.cfg_line_step;
            scan_step        <= bus.cfg_scan_step;
            reverse          <= bus.cfg_reverse;
            prime_cnt        <= TAP_W'(NUM_PARTITIONS - 1);
            scan_k           <= '0;
            err_count        <= '0;
            pass             <= 1'b0;
            proto_err        <= 1'b0;
            first_err_valid  <= 1'b0;
            first_err_scan   <= '0;
            first_err_tap    <= '0;
            first_err_actual <= '0;
            state            <= ST_PRIME;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PRIME: begin
          if (bus.pe_en) proto_err <= 1'b1;
          // Shift register seeding: after NUM_PARTITIONS pushes, s0 lands in acc[0]
          acc[NUM_PARTITIONS-1] <= prime_sum;
          for (int i = 0; i < NUM_PARTITIONS - 1; i++) acc[i] <= acc[i+1];
          prime_sum <= prime_sum + line_step;
          if (prime_cnt == '0) state <= ST_ARMED;
          else prime_cnt <= prime_cnt - 1'b1;
        end
        ST_ARMED, ST_SCAN: begin
          if (compare) begin
            err_count <= (err_sum > ERR_MAX) ? {ERR_CNT_WIDTH{1'b1}} : ERR_CNT_WIDTH'(err_sum);
            if ((|mism) && !first_err_valid) begin
              first_err_valid  <= 1'b1;
              first_err_scan   <= reverse ? (K_LAST - scan_k) : scan_k;
              first_err_tap    <= first_idx;
              first_err_actual <= tap[first_idx];
            end
            for (int i = 0; i < NUM_PARTITIONS; i++) acc[i] <= acc[i] + scan_step;
            scan_k <= scan_k + 1'b1;
            if (scan_k == K_LAST) begin
              pass  <= !proto_err && !first_err_valid && !(|mism);
              state <= ST_DONE;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy             = (state == ST_PRIME) || (state == ST_ARMED) || (state == ST_SCAN);
  assign bus.done             = (state == ST_DONE);
  assign bus.pass             = pass;
  assign bus.err_count        = err_count;
  assign bus.first_err_valid  = first_err_valid;
  assign bus.first_err_scan   = first_err_scan;
  assign bus.first_err_tap    = first_err_tap;
  assign bus.first_err_actual = first_err_actual;
endmodule

// File: tb/tb_nabp_processing_data_path_checker.sv
// Self-checking bench: RAM-stub delay, full scan runs with tolerance, stalls, saturation,
// protocol error and mid-run reset, checked against a closed-form position model.
module tb_nabp_processing_data_path_checker;
  localparam int NP   = 4;
  localparam int SL   = 256;
  localparam int DW   = 16;
  localparam int SW   = 10;
  localparam int NPRT = 2;
  localparam int ECW  = 4;
  localparam int LAT  = 2;
  localparam int TOL  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int offs [SL][NP];

  always #5 clk = ~clk;

  nabp_processing_data_path_checker_if #(
    .NUM_PORTS(NPRT), .S_WIDTH(SW), .DATA_WIDTH(DW), .NUM_PARTITIONS(NP),
    .FRAC_BITS(8), .ERR_CNT_WIDTH(ECW)
  ) bus ();

  nabp_processing_data_path_checker #(
    .NUM_PORTS(NPRT), .S_WIDTH(SW), .DATA_WIDTH(DW), .NUM_PARTITIONS(NP),
    .RAM_LATENCY(LAT), .FRAC_BITS(8), .TOLERANCE(TOL), .SCAN_LENGTH(SL),
    .ERR_CNT_WIDTH(ECW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Nearest integer (half up) of the fixed-point position s0 + i*line + k*scan, kept to DW bits
  function automatic int exp_of(input longint s0, input longint ls, input longint ss,
                                input int k, input int i);
    longint a;
    a = s0 + longint'(i) * ls + longint'(k) * ss;
    return int'(((a + 128) >>> 8) & 64'hffff);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic clear_offs(input int v);
    for (int k = 0; k < SL; k++)
      for (int i = 0; i < NP; i++) offs[k][i] = v;
  endtask

  // One full run; abort_at >= 0 pulls reset at that scan step instead of finishing
  task automatic do_run(input string name, input longint s0, input longint ls, input longint ss,
                        input bit rev, input int stall_at, input int stall_len,
                        input bit prime_pulse, input int abort_at);
    int errs = 0;
    bit fv = 0;
    int fscan = 0, ftap = 0, fact = 0;
    int e, t;
    @(negedge clk);
    bus.cfg_s0 = 19'(s0);
    bus.cfg_line_step = 19'(ls);
    bus.cfg_scan_step = 19'(ss);
    bus.cfg_reverse = rev;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    chk({name, " busy_at_start"}, bus.busy, 1);
    chk({name, " cleared_err"}, bus.err_count, 0);
    if (prime_pulse) bus.pe_en = 1'b1;
    @(negedge clk);
    bus.pe_en = 1'b0;
    repeat (NP - 1) @(negedge clk);
    for (int k = 0; k < SL; k++) begin
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk({name, " abort_busy"}, bus.busy, 0);
        chk({name, " abort_err"}, bus.err_count, 0);
        chk({name, " abort_pv_val"}, bus.pv_val, 0);
        chk({name, " abort_done"}, bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk({name, " no_done_after_abort"}, bus.done, 0);
        end
        chk({name, " idle_after_abort"}, bus.busy, 0);
        return;
      end
      if (k == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk);
          chk({name, " stall_no_done"}, bus.done, 0);
        end
      end
      bus.pe_en = 1'b1;
      for (int i = 0; i < NP; i++) begin
        e = exp_of(s0, ls, ss, k, i);
        t = (e + offs[k][i]) & 16'hffff;
        bus.pe_taps[i*DW +: DW] = 16'(t);
        if (offs[k][i] > TOL || offs[k][i] < -TOL) begin
          errs++;
          if (!fv) begin
            fv = 1;
            fscan = rev ? (SL - 1 - k) : k;
            ftap = i;
            fact = t;
          end
        end
      end
      @(negedge clk);
      bus.pe_en = 1'b0;
      if (k < SL - 1) chk({name, " no_early_done"}, bus.done, 0);
    end
    chk({name, " done"}, bus.done, 1);
    chk({name, " busy_in_done"}, bus.busy, 0);
    chk({name, " pass"}, bus.pass, (!fv && !prime_pulse) ? 1 : 0);
    chk({name, " err_count"}, bus.err_count, (errs > 15) ? 15 : errs);
    chk({name, " first_err_valid"}, bus.first_err_valid, fv);
    if (fv) begin
      chk({name, " first_err_scan"}, bus.first_err_scan, fscan);
      chk({name, " first_err_tap"}, bus.first_err_tap, ftap);
      chk({name, " first_err_actual"}, bus.first_err_actual, fact);
    end
    @(negedge clk);
    chk({name, " done_one_cycle"}, bus.done, 0);
  endtask

  task automatic test_reset();
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst pass", bus.pass, 0);
    chk("rst err_count", bus.err_count, 0);
    chk("rst first_err_valid", bus.first_err_valid, 0);
    chk("rst pv_val", bus.pv_val, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ram_stub();
    logic [NPRT*SW-1:0] hist [$];
    logic [NPRT*SW-1:0] s;
    logic [NPRT*DW-1:0] want;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        s = hist[c - LAT];
        want = '0;
        for (int p = 0; p < NPRT; p++) want[p*DW +: DW] = DW'(s[p*SW +: SW]);
        chk("ram_stub pv_val", bus.pv_val, want);
      end
      if (c == 0) s = {10'd77, 10'd5};
      else if (c == 1) s = {10'd77, 10'd1023};
      else s = NPRT*SW'($urandom);
      bus.pv_s_val = s;
      hist.push_back(s);
    end
    bus.pv_s_val = 20'h5a5a5;
  endtask

  task automatic test_exact();
    clear_offs(0);
    do_run("exact", 100 * 256, 64 * 256, 128, 0, -1, 0, 0, -1);
  endtask

  task automatic test_tolerance();
    clear_offs(0);
    offs[10][2] = 3;
    offs[11][2] = 4;
    offs[12][1] = -3;
    do_run("tolerance", 100 * 256, 64 * 256, 128, 0, -1, 0, 0, -1);
  endtask

  task automatic test_stall();
    clear_offs(0);
    do_run("stall", 37 * 256 + 77, 50 * 256 + 3, 200, 0, 50, 5, 0, -1);
  endtask

  task automatic test_saturate_reverse();
    clear_offs(10);
    do_run("saturate_rev", 100 * 256, 64 * 256, 128, 1, -1, 0, 0, -1);
    clear_offs(0);
    do_run("prime_protocol", 100 * 256, 64 * 256, 128, 0, -1, 0, 1, -1);
  endtask

  task automatic test_abort();
    clear_offs(0);
    do_run("abort", 100 * 256, 64 * 256, 128, 0, -1, 0, 0, 100);
    do_run("after_abort", 100 * 256, 64 * 256, 128, 0, -1, 0, 0, -1);
  endtask

  task automatic test_random();
    longint s0, ls, ss;
    for (int r = 0; r < 3; r++) begin
      clear_offs(0);
      for (int k = 0; k < SL; k++)
        for (int i = 0; i < NP; i++)
          if ($urandom_range(0, 99) < 4) offs[k][i] = int'($urandom_range(0, 12)) - 6;
      s0 = longint'($urandom_range(0, 200 * 256));
      ls = longint'($urandom_range(0, 40 * 256)) - 20 * 256;
      ss = longint'($urandom_range(0, 768)) - 384;
      do_run("random", s0, ls, ss, r[0], int'($urandom_range(1, SL - 1)),
             int'($urandom_range(1, 6)), 0, -1);
    end
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_s0 = '0;
    bus.cfg_line_step = '0;
    bus.cfg_scan_step = '0;
    bus.cfg_reverse = 1'b0;
    bus.pv_s_val = '0;
    bus.pe_en = 1'b0;
    bus.pe_taps = '0;
    test_reset();
    test_ram_stub();
    test_exact();
    test_tolerance();
    test_stall();
    test_saturate_reverse();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nabp_processing_data_path_checker.md
Name: nabp_processing_data_path_checker

Overview:
Synthesisable, parametrised checker for the processing-swappable data path. It stands in for the filtered RAM on NUM_PORTS read ports, returning each port's S address as data after RAM_LATENCY cycles. It also scores every processing-element tap on each enabled scan cycle against an incrementally computed expected projection line position, within a configurable tolerance. It replaces simulation-only trig evaluation with host-supplied fixed-point per-angle steps, so it runs on FPGA as well as in simulation.

Parameters:
NUM_PORTS, 2, filtered-RAM read ports emulated
S_WIDTH, 10, width of S address per port
DATA_WIDTH, 16, filtered data / tap width
NUM_PARTITIONS, 4, PE taps checked per cycle
RAM_LATENCY, 1, read latency of emulated RAM (0..4; 0 = combinational)
FRAC_BITS, 8, fractional bits of fixed-point config values
TOLERANCE, 3, maximum allowed |expected - actual|
SCAN_LENGTH, 256, enabled cycles per angle (image size)
ERR_CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_start  in  1  pulse; latches cfg_* and begins a run
cfg_s0  in  S_WIDTH+FRAC_BITS+1  signed fixed-point expected S for partition 0, scan step 0
cfg_line_step  in  S_WIDTH+FRAC_BITS+1  signed S increment between partitions
cfg_scan_step  in  S_WIDTH+FRAC_BITS+1  signed S increment per scan step
cfg_reverse  in  1  scan runs high-to-low; affects reported scan index only
pv_s_val  in  NUM_PORTS*S_WIDTH  packed read addresses, port p at [S_WIDTH*(p+1)-1 : S_WIDTH*p]
pv_val  out  NUM_PORTS*DATA_WIDTH  packed read data
pe_en  in  1  PE taps valid this cycle
pe_taps  in  NUM_PARTITIONS*DATA_WIDTH  packed taps, partition i at the i-th slice
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  level; 1 when the last run had no errors and no protocol error
err_count  out  ERR_CNT_WIDTH  mismatching taps, saturating
first_err_valid  out  1  a mismatch has been captured
first_err_scan  out  S_WIDTH  scan index of the first mismatch
first_err_tap  out  clog2(NUM_PARTITIONS)  partition of the first mismatch
first_err_actual  out  DATA_WIDTH  tap value at the first mismatch

Behaviour:
- Reset: all outputs 0, RAM pipeline 0, state IDLE.
- RAM stub: pv_val[p] = zero-extended pv_s_val[p], delayed by exactly RAM_LATENCY clocks through a register pipeline. Independent of the FSM; always active.
- FSM: IDLE -> PRIME -> ARMED -> SCAN -> DONE -> IDLE.
  - IDLE/DONE: cfg_start latches config, clears err_count, pass, first_err_* and the protocol-error flag, then enters PRIME. cfg_start in any other state is ignored.
  - PRIME (NUM_PARTITIONS cycles): loads accumulators sequentially, acc[0] = s0, acc[i] = acc[i-1] + line_step.
  - ARMED: waits for pe_en=1; that cycle is scan step k=0 and is compared immediately (state becomes SCAN).
  - SCAN: every pe_en=1 cycle compares all taps, then acc[i] += scan_step and k++. pe_en=0 stalls; no compare and no advance.
  - After SCAN_LENGTH compared cycles -> DONE (one cycle): done=1, busy=0, pass updated.
- busy = 1 in PRIME, ARMED and SCAN.
- pe_en=1 during PRIME sets a sticky protocol error. pass is forced to 0; err_count is unaffected.
- Expected value: exp_i = (acc[i] + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up), truncated to DATA_WIDTH.
- Difference: diff = exp_i - tap_i, computed signed at DATA_WIDTH+1 bits. Mismatch when diff < -TOLERANCE or diff > TOLERANCE.
- err_count adds the number of mismatching taps in the cycle and saturates at all-ones.
- First-error capture: on the first cycle with any mismatch, record the lowest mismatching tap index and set first_err_valid.
  - first_err_scan = k, or SCAN_LENGTH-1-k when cfg_reverse=1.
- Accumulator width is S_WIDTH+FRAC_BITS+1 and wraps two's-complement. Any overflow is the host's error.
- Asynchronous reset mid-run aborts immediately to reset values. No done pulse is produced.

Test Plan:
1. RAM_LATENCY=2; pv_s_val port0 = 5 at cycle t, 1023 at t+1 -> pv_val port0 = 5 at t+2, 1023 at t+3; port1 unaffected.
2. s0=100.0, line_step=64.0, scan_step=0.5, taps driven exact (rounded, e.g. 100.5 -> 101), 256 continuous pe_en cycles -> single done pulse, pass=1, err_count=0, first_err_valid=0.
3. Tolerance boundary: tap2 at exp+3 for k=10 -> no error; tap2 at exp+4 for k=11 -> err_count=1, first_err_scan=11, first_err_tap=2, first_err_actual=exp+4, pass=0.
4. Stall: pe_en low for 5 cycles at k=50 -> expected values hold; done exactly after the 256th enabled cycle; pass=1.
5. ERR_CNT_WIDTH=4, cfg_reverse=1, all taps wrong from k=0 -> err_count saturates at 15, first_err_scan=255, first_err_tap=0; pe_en pulse during PRIME on a rerun -> pass=0 with err_count=0.
6. reset_n low at k=100 -> busy=0, err_count=0, pv_val=0, no done; a subsequent cfg_start run completes normally with pass=1.
